tick_pwm_generator: RTL and testbench
=====================================

Name: tick_pwm_generator

Overview:
Downstream consumer of the clock divider's square-wave output. It synchronises the divided signal into the system clock domain and turns each rising edge into a one-cycle tick. It then runs a period/duty PWM counter advanced only on ticks. A valid/ready config port updates period and duty glitch-free at period boundaries.

Parameters:
CNT_W, 8, width of period, duty and tick counter
SYNC_STAGES, 2, synchroniser flops on div_in (minimum 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
div_in  input  1  divided square wave from clock divider (asynchronous to clk logic; treat as async)
en  input  1  run enable, level
cfg_valid  input  1  config offer
cfg_ready  output  1  shadow register free
cfg_period  input  CNT_W  ticks per PWM period; 0 = disabled
cfg_duty  input  CNT_W  ticks high per period
tick  output  1  one-cycle pulse per synchronised div_in rising edge
pwm_out  output  1  PWM waveform, registered
period_done  output  1  one-cycle pulse on period wrap

Behaviour:
- Reset (reset=0, async): sync flops 0, tick 0, cnt 0, period_r 0, duty_r 0, pending 0, cfg_ready 1, pwm_out 0, period_done 0, state IDLE.
- Sync: div_in passes through SYNC_STAGES flops plus one history flop. tick = last_sync & ~history, combinational from registers.
- Tick latency: div_in rise sampled at edge k gives tick high for the cycle after edge k+SYNC_STAGES-1. Falling edges give no tick.
- Config handshake: transfer when cfg_valid & cfg_ready.
  - On transfer, the shadow captures period/duty, pending<=1 and cfg_ready<=0 next cycle.
  - cfg_valid while not ready is ignored; it is not queued.
- State IDLE: cnt 0, pwm_out 0.
  - If pending, apply the shadow to period_r/duty_r next edge and clear pending (cfg_ready returns 1).
  - Go to RUN when en=1 and period_r!=0.
- State RUN:
  - On a tick with cnt==period_r-1: cnt<=0, period_done<=1 for one cycle. If pending, load the shadow into period_r/duty_r on this same edge and clear pending.
  - On a tick otherwise: cnt<=cnt+1.
  - No tick: hold.
- pwm_out register: next value = RUN_next & (cnt_next < duty_r_next).
  - duty >= period gives constant 1.
  - duty 0 gives constant 0.
- en deassert in RUN: next edge state IDLE, cnt 0, pwm_out 0, and no period_done. A pending shadow is then applied in IDLE.
- New period_r==0 loaded at a wrap: go to IDLE.
- Simultaneous tick at wrap + config transfer in the same cycle: the old pending (if any) loads. The new transfer cannot occur because cfg_ready was 0. If not pending, the transfer fills the shadow, which is applied at the next wrap.
- Width: cnt is CNT_W bits and never exceeds period_r-1, so there is no overflow.
- Mid-operation reset clears everything immediately (async assert). Deassertion is assumed synchronised upstream.

Decomposition:
- Package tick_pwm_pkg: state enum {IDLE, RUN}, and constant MIN_SYNC_STAGES=2.
- One sub-module, tick_edge_sync: synchroniser chain + rising-edge detect, with params SYNC_STAGES. It outputs tick.
- PWM FSM, counter and shadow logic live in the top.

Test Plan:
1. Reset: hold reset=0 with div_in toggling. Expect tick=0, pwm_out=0, cfg_ready=1. Release: first tick exactly SYNC_STAGES cycles after the first sampled div_in rise.
2. Config period=4, duty=1, en=1, div_in period 10 clk. Expect pwm_out high 1 tick-interval of every 4. period_done pulses every 4th tick. cfg_ready=1 after the IDLE apply.
3. Running period=4, duty=1: offer period=5, duty=3 mid-period. Expect cfg_ready=0 until the next wrap. The next period is 5 ticks with 3 high, and there are no runt pulses.
4. Boundaries: duty=0 gives pwm_out constant 0. duty=4 with period=4 gives constant 1. period=0 keeps the block in IDLE with pwm_out=0.
5. Deassert en mid-period (cnt=2). Expect pwm_out=0 and cnt=0 next cycle, no period_done. Re-enable: the count restarts at 0 with pwm_out=1 (duty>0).
6. Assert reset asynchronously between clk edges while pending=1. Expect outputs cleared immediately, pending dropped, cfg_ready=1 after release.

Source files
------------

// File: rtl/tick_pwm_pkg.sv
// rtl/tick_pwm_pkg.sv - shared types and constants for the tick-driven PWM generator
package tick_pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/tick_edge_sync.sv
// rtl/tick_edge_sync.sv - synchronises div_in into clk and emits a one-cycle tick per rising edge
module tick_edge_sync
  import tick_pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic div_in,
  output logic tick
);

  // Fewer than two flops is not a safe synchroniser, so clamp upward.
  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync;
  logic              history;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync    <= '0;
      history <= 1'b0;
    end else begin
      sync    <= {sync[STAGES-2:0], div_in};
      history <= sync[STAGES-1];
    end
  end

  assign tick = sync[STAGES-1] & ~history;

endmodule

// File: rtl/tick_pwm_generator.sv
// rtl/tick_pwm_generator.sv - PWM counter advanced on synchronised div_in ticks,
// with a one-deep shadow config applied only at period boundaries or while idle
module tick_pwm_generator
  import tick_pwm_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             tick,
  output logic             pwm_out,
  output logic             period_done
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] period_r, period_next;
  logic [CNT_W-1:0] duty_r, duty_next;
  logic [CNT_W-1:0] sh_period, sh_duty;
  logic             pending, pending_next;
  logic             pwm_next, done_next;
  logic             xfer, at_last;

  tick_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .div_in(div_in),
    .tick  (tick)
  );

  assign cfg_ready = ~pending;
  assign xfer      = cfg_valid & cfg_ready;
  assign at_last   = (cnt == period_r - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      period_r    <= '0;
      duty_r      <= '0;
      sh_period   <= '0;
      sh_duty     <= '0;
      pending     <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      period_r    <= period_next;
      duty_r      <= duty_next;
      pending     <= pending_next;
      pwm_out     <= pwm_next;
      period_done <= done_next;
      if (xfer) begin
        sh_period <= cfg_period;
        sh_duty   <= cfg_duty;
      end
    end
  end

  // A transfer can never coincide with an apply: cfg_ready is low whenever pending is set.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    period_next  = period_r;
    duty_next    = duty_r;
    pending_next = pending | xfer;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (pending) begin
          period_next  = sh_period;
          duty_next    = sh_duty;
          pending_next = 1'b0;
        end
        if (en && period_r != '0) state_next = RUN;
      end
      RUN: begin
        if (!en || period_r == '0) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (tick) begin
          if (at_last) begin
            cnt_next = '0;
            if (pending) begin
              period_next  = sh_period;
              duty_next    = sh_duty;
              pending_next = 1'b0;
              if (sh_period == '0) state_next = IDLE;
            end
          end else begin
            cnt_next = cnt + ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done_next = (state == RUN) && en && (period_r != '0) && tick && at_last;
    pwm_next  = (state_next == RUN) && (cnt_next < duty_next);
  end

endmodule

// File: tb/tb_tick_pwm_generator.sv
// tb/tb_tick_pwm_generator.sv - directed self-checking bench for tick_pwm_generator
module tb_tick_pwm_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       div_in = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_period = 8'd0;
  logic [7:0] cfg_duty = 8'd0;
  logic       cfg_ready, tick, pwm_out, period_done;

  int checks = 0;
  int failures = 0;

  tick_pwm_generator #(
    .CNT_W      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .div_in     (div_in),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .tick       (tick),
    .pwm_out    (pwm_out),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] p, input logic [7:0] d);
    cfg_period = p;
    cfg_duty   = d;
    cfg_valid  = 1'b1;
    step();
    cfg_valid  = 1'b0;
  endtask

  // One div_in period of 10 clocks (5 high, 5 low); checks the settled pwm, any period_done, and a single tick.
  task automatic cyc(input string tag, input logic pwm_e, input logic done_e);
    logic done_o;
    int   ticks_o;
    done_o  = 1'b0;
    ticks_o = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (period_done === 1'b1) done_o = 1'b1;
      if (tick === 1'b1) ticks_o++;
      div_in = (i < 5);
    end
    check({tag, "_pwm"}, pwm_out, pwm_e);
    check({tag, "_done"}, done_o, done_e);
    check({tag, "_onetick"}, (ticks_o == 1), 1'b1);
  endtask

  logic [7:0] exp_pwm3, exp_done3, exp_rdy3;

  initial begin
    // 1: reset with div_in toggling, then tick latency
    for (int i = 0; i < 6; i++) begin
      step();
      div_in = ~div_in;
    end
    check("rst_tick", tick, 1'b0);
    check("rst_pwm", pwm_out, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_done", period_done, 1'b0);
    div_in = 1'b0;
    step();
    reset = 1'b1;
    step(); step(); step();
    check("post_rst_tick", tick, 1'b0);
    div_in = 1'b1;
    step();
    check("lat_edge_k", tick, 1'b0);
    step();
    check("lat_edge_k1", tick, 1'b1);
    step();
    check("lat_one_cycle", tick, 1'b0);
    div_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fall_no_tick", tick, 1'b0);
    end

    // 2: period 4, duty 1
    offer(8'd4, 8'd1);
    check("cfg_busy", cfg_ready, 1'b0);
    step();
    check("cfg_idle_apply", cfg_ready, 1'b1);
    en = 1'b1;
    step();
    check("run_start_pwm", pwm_out, 1'b1);
    for (int k = 0; k < 8; k++) cyc("p4d1", (k % 4 == 3), (k % 4 == 3));

    // 3: mid-period reconfig to period 5, duty 3
    cyc("pre_cfg", 1'b0, 1'b0);
    offer(8'd5, 8'd3);
    check("mid_cfg_busy", cfg_ready, 1'b0);
    exp_pwm3  = 8'b1001_1100;
    exp_done3 = 8'b1000_0100;
    exp_rdy3  = 8'b1111_1100;
    for (int k = 0; k < 8; k++) begin
      cyc("p5d3", exp_pwm3[k], exp_done3[k]);
      check("p5d3_ready", cfg_ready, exp_rdy3[k]);
    end

    // 4: duty 0, duty == period, period 0
    offer(8'd5, 8'd0);
    cyc("to_d0_1", 1'b1, 1'b0);
    cyc("to_d0_2", 1'b1, 1'b0);
    cyc("to_d0_3", 1'b0, 1'b0);
    cyc("to_d0_4", 1'b0, 1'b0);
    cyc("to_d0_wrap", 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cyc("duty0", 1'b0, (k == 4));
    offer(8'd4, 8'd4);
    for (int k = 0; k < 5; k++) cyc("to_d4", (k == 4), (k == 4));
    for (int k = 0; k < 4; k++) cyc("duty_eq_period", 1'b1, (k == 3));
    offer(8'd0, 8'd2);
    for (int k = 0; k < 4; k++) cyc("to_p0", (k != 3), (k == 3));
    check("p0_ready", cfg_ready, 1'b1);
    for (int k = 0; k < 3; k++) cyc("period0_idle", 1'b0, 1'b0);

    // 5: en deassert mid-period, re-enable restarts at 0
    offer(8'd4, 8'd3);
    step();
    check("p4d3_applied", cfg_ready, 1'b1);
    step();
    check("p4d3_start", pwm_out, 1'b1);
    cyc("p4d3_c1", 1'b1, 1'b0);
    cyc("p4d3_c2", 1'b1, 1'b0);
    en = 1'b0;
    step();
    check("en_off_pwm", pwm_out, 1'b0);
    check("en_off_done", period_done, 1'b0);
    step();
    check("en_off_done2", period_done, 1'b0);
    en = 1'b1;
    step();
    check("reen_pwm", pwm_out, 1'b1);
    cyc("reen_c1", 1'b1, 1'b0);
    cyc("reen_c2", 1'b1, 1'b0);
    cyc("reen_c3", 1'b0, 1'b0);
    cyc("reen_wrap", 1'b1, 1'b1);

    // 6: async reset while a config is pending
    offer(8'd6, 8'd1);
    check("pend_busy", cfg_ready, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_pwm", pwm_out, 1'b0);
    check("arst_ready", cfg_ready, 1'b1);
    check("arst_done", period_done, 1'b0);
    check("arst_tick", tick, 1'b0);
    step(); step();
    reset = 1'b1;
    check("rel_ready", cfg_ready, 1'b1);
    check("rel_pwm", pwm_out, 1'b0);
    cyc("rel_idle1", 1'b0, 1'b0);
    cyc("rel_idle2", 1'b0, 1'b0);
    check("rel_ready_end", cfg_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
